// File: rtl/maxpool_reduce_writer_if.sv
// Handshake and control bundle between the pooling data path and its surroundings.
// The master side drives start, sizes and the pixel stream; the slave side is the reducer.
interface maxpool_reduce_writer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
);
    logic              start;
    logic [4:0]        pool_w;
    logic [4:0]        pool_h;
    logic [9:0]        out_w;
    logic [9:0]        out_h;
    logic [ADDR_W-1:0] wr_base;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              patch_end;
    logic              overrun;

    modport master (
        output start, pool_w, pool_h, out_w, out_h, wr_base, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, patch_end, overrun
    );

    modport slave (
        input  start, pool_w, pool_h, out_w, out_h, wr_base, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, patch_end, overrun
    );
endinterface

// File: rtl/maxpool_reduce_writer.sv
// Reduces a patch-ordered pixel stream to one signed maximum per patch and writes
// each result to the pooled-output RAM at base + patch index.
module maxpool_reduce_writer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    maxpool_reduce_writer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic [9:0]                psize_q, psize_d;
    logic [19:0]               total_q, total_d;
    logic [ADDR_W-1:0]         base_q, base_d;
    logic [9:0]                elem_cnt_q, elem_cnt_d;
    logic [19:0]               out_idx_q, out_idx_d;
    logic signed [DATA_W-1:0]  max_q, max_d;
    logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]         wr_data_q, wr_data_d;
    logic                      overrun_q, overrun_d;
    logic                      in_ready_q, wr_en_q, busy_q, done_q;

    logic                      start_ok_s;
    logic                      accept_s;
    logic [9:0]                psize_new_s;
    logic [19:0]               total_new_s;
    logic [ADDR_W-1:0]         addr_sum_s;

    assign start_ok_s  = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign accept_s    = bus.in_valid && (state_q == ST_ACCUM);
    assign psize_new_s = 10'(bus.pool_w) * 10'(bus.pool_h);
    assign total_new_s = 20'(bus.out_w) * 20'(bus.out_h);
    assign addr_sum_s  = base_q + ADDR_W'(out_idx_q);

    // Next-state, datapath and latched-size logic
    always_comb begin
        state_d    = state_q;
        psize_d    = psize_q;
        total_d    = total_q;
        base_d     = base_q;
        elem_cnt_d = elem_cnt_q;
        out_idx_d  = out_idx_q;
        max_d      = max_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        overrun_d  = overrun_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok_s) begin
                    psize_d    = psize_new_s;
                    total_d    = total_new_s;
                    base_d     = bus.wr_base;
                    elem_cnt_d = 10'd0;
                    out_idx_d  = 20'd0;
                    overrun_d  = 1'b0;
                    if ((psize_new_s == 10'd0) || (total_new_s == 20'd0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end else if (bus.in_valid) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end
            ST_ACCUM: begin
                if (accept_s) begin
                    // First sample of a patch always replaces the running maximum
                    if (elem_cnt_q == 10'd0) begin
                        max_d = $signed(bus.in_data);
                    end else if ($signed(bus.in_data) > max_q) begin
                        max_d = $signed(bus.in_data);
                    end else begin
                        max_d = max_q;
                    end
                    if (elem_cnt_q == (psize_q - 10'd1)) begin
                        elem_cnt_d = 10'd0;
                        state_d    = ST_WRITE;
                        wr_data_d  = max_d;
                        wr_addr_d  = addr_sum_s;
                    end else begin
                        elem_cnt_d = elem_cnt_q + 10'd1;
                    end
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_WRITE: begin
                if (out_idx_q == (total_q - 20'd1)) begin
                    state_d = ST_DONE;
                end else begin
                    out_idx_d = out_idx_q + 20'd1;
                    state_d   = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered-output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            psize_q    <= 10'd0;
            total_q    <= 20'd0;
            base_q     <= '0;
            elem_cnt_q <= 10'd0;
            out_idx_q  <= 20'd0;
            max_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            overrun_q  <= 1'b0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            psize_q    <= psize_d;
            total_q    <= total_d;
            base_q     <= base_d;
            elem_cnt_q <= elem_cnt_d;
            out_idx_q  <= out_idx_d;
            max_q      <= max_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            overrun_q  <= overrun_d;
            in_ready_q <= (state_d == ST_ACCUM);
            wr_en_q    <= (state_d == ST_WRITE);
            busy_q     <= (state_d == ST_ACCUM) || (state_d == ST_WRITE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.patch_end = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;
endmodule
